// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: writeback result selects, load funct3 codes and the
// writeback-stage state type.
package rv32_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {IDLE, WAIT_MEM} wb_state_t;

  // True when funct3 encodes one of the supported load widths.
  function automatic logic load_f3_legal(input logic [2:0] funct3);
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half lane from a word-aligned read
// and extends it; flags illegal funct3 and misaligned halfword/word accesses.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    err_o  = !load_f3_legal(funct3_i);
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {24'b0, byte_sel};
      F3_LH: begin
        data_o = {{16{half_sel[15]}}, half_sel};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {16'b0, half_sel};
        err_o  = addr_lo_i[0];
      end
      F3_LW:   err_o = (addr_lo_i != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rv32 writeback stage: drives the register-file write port from ALU, PC+4 or
// aligned load data. Define WB_INSTRET_EN to build the 64-bit retire counter.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic [1:0]            in_sel,
  input  logic [XLEN-1:0]       in_result,
  input  logic [XLEN-1:0]       in_pc4,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [REG_ADDR_W-1:0] wa,
  output logic [XLEN-1:0]       wda,
  output logic                  reg_wr,
  output logic                  load_err,
  output logic [63:0]           instret
);

  wb_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wr_en_q, wr_en_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  logic [XLEN-1:0]       wda_q, wda_d;
  logic                  reg_wr_q, reg_wr_d;
  logic                  load_err_q, load_err_d;
  logic                  retire;
  logic [XLEN-1:0]       align_data;
  logic                  align_err;

  load_align u_load_align (
    .rdata_i   (mem_rdata),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .data_o    (align_data),
    .err_o     (align_err)
  );

  assign in_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_en_d    = wr_en_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    wa_d       = wa_q;
    wda_d      = wda_q;
    reg_wr_d   = 1'b0;
    load_err_d = 1'b0;
    retire     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          unique case (in_sel)
            SEL_ALU, SEL_PC4: begin
              wa_d     = in_rd;
              wda_d    = (in_sel == SEL_PC4) ? in_pc4 : in_result;
              reg_wr_d = in_wr_en && (in_rd != '0);
              retire   = 1'b1;
            end
            SEL_NONE: retire = 1'b1;
            SEL_LOAD: begin
              rd_d      = in_rd;
              wr_en_d   = in_wr_en;
              funct3_d  = in_funct3;
              addr_lo_d = in_addr_lo;
              state_d   = WAIT_MEM;
            end
          endcase
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (align_err) begin
            load_err_d = 1'b1;
          end else begin
            wa_d     = rd_q;
            wda_d    = align_data;
            reg_wr_d = wr_en_q && (rd_q != '0);
            retire   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wr_en_q    <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wa_q       <= '0;
      wda_q      <= '0;
      reg_wr_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_en_q    <= wr_en_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      wa_q       <= wa_d;
      wda_q      <= wda_d;
      reg_wr_q   <= reg_wr_d;
      load_err_q <= load_err_d;
    end
  end

  assign wa       = wa_q;
  assign wda      = wda_q;
  assign reg_wr   = reg_wr_q;
  assign load_err = load_err_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized instruction
// mix checked against a behavioural writeback model.
module tb_wb_stage;
  import rv32_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic [1:0]  in_sel;
  logic [31:0] in_result;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  wa;
  logic [31:0] wda;
  logic        reg_wr;
  logic        load_err;
  logic [63:0] instret;

  int          vectors = 0;
  int          errs    = 0;
  longint unsigned exp_ret = 0;

  wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wr_en   (in_wr_en),
    .in_sel     (in_sel),
    .in_result  (in_result),
    .in_pc4     (in_pc4),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wa         (wa),
    .wda        (wda),
    .reg_wr     (reg_wr),
    .load_err   (load_err),
    .instret    (instret)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ir_exp();
`ifdef WB_INSTRET_EN
    return exp_ret;
`else
    return 64'd0;
`endif
  endfunction

  // Reference: shift the addressed lane down, then extend by width/sign rules.
  function automatic void load_model(input logic [31:0] rdata, input logic [2:0] f3,
                                     input logic [1:0] lo, output logic err,
                                     output logic [31:0] val);
    logic [31:0] s;
    s   = rdata >> (8 * lo);
    err = 1'b0;
    val = rdata;
    case (f3)
      3'd0: val = 32'($signed(s[7:0]));
      3'd4: val = s & 32'h0000_00ff;
      3'd1: begin err = lo[0]; val = 32'($signed(s[15:0])); end
      3'd5: begin err = lo[0]; val = s & 32'h0000_ffff; end
      3'd2: err = (lo != 2'd0);
      default: err = 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic [1:0] sel, input logic [4:0] rd, input logic wr,
                       input logic [31:0] res, input logic [31:0] pc4);
    logic [31:0] exp_d;
    chk("op_ready", in_ready, 1'b1);
    in_sel = sel; in_rd = rd; in_wr_en = wr; in_result = res; in_pc4 = pc4;
    in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_d = (sel == 2'b10) ? pc4 : res;
    if (sel != 2'b11) begin
      chk("op_wa", wa, rd);
      chk("op_wda", wda, exp_d);
    end
    chk("op_reg_wr", reg_wr, (sel != 2'b11) && wr && (rd != 5'd0));
    chk("op_load_err", load_err, 1'b0);
    exp_ret++;
    chk("op_instret", instret, ir_exp());
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic wr, input logic [31:0] rdata, input int waits,
                         input bit noise);
    logic        err;
    logic [31:0] val;
    chk("ld_ready", in_ready, 1'b1);
    in_sel = 2'b01; in_rd = rd; in_wr_en = wr; in_funct3 = f3; in_addr_lo = lo;
    in_result = $urandom; in_valid = 1'b1;
    tick();
    // Upstream offers another op while the stage is busy; it must be ignored.
    in_valid = noise;
    in_sel = 2'b00; in_rd = 5'd7; in_wr_en = 1'b1;
    chk("ld_xfer_wr", reg_wr, 1'b0);
    for (int i = 0; i < waits; i++) begin
      chk("ld_wait_ready", in_ready, 1'b0);
      chk("ld_wait_wr", reg_wr, 1'b0);
      tick();
    end
    chk("ld_wait_ready", in_ready, 1'b0);
    in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    load_model(rdata, f3, lo, err, val);
    chk("ld_err", load_err, err);
    chk("ld_reg_wr", reg_wr, !err && wr && (rd != 5'd0));
    if (!err) begin
      chk("ld_wa", wa, rd);
      chk("ld_wda", wda, val);
      exp_ret++;
    end
    chk("ld_instret", instret, ir_exp());
    chk("ld_ready_back", in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wr_en = 1'b0; in_sel = '0;
    in_result = '0; in_pc4 = '0; in_funct3 = '0; in_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    tick();
    tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_wa", wa, 5'd0);
    chk("rst_wda", wda, 32'd0);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_instret", instret, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    // Single ALU write, then confirm the pulse lasts one cycle.
    do_op(2'b00, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("alu_pulse_end", reg_wr, 1'b0);

    do_load(3'd0, 2'd3, 5'd9, 1'b1, 32'h80FF_FF7F, 4, 1'b1);
    do_load(3'd5, 2'd2, 5'd10, 1'b1, 32'hABCD_1234, 1, 1'b0);
    do_load(3'd2, 2'd1, 5'd11, 1'b1, 32'h1234_5678, 2, 1'b0);
    tick();
    chk("err_pulse_end", load_err, 1'b0);

    // Back-to-back ALU ops; rd=0 must not write.
    do_op(2'b00, 5'd0, 1'b1, 32'h1111_1111, 32'h0);
    do_op(2'b00, 5'd1, 1'b1, 32'h2222_2222, 32'h0);
    do_op(2'b00, 5'd2, 1'b1, 32'h3333_3333, 32'h0);
    tick();
    chk("b2b_idle_wr", reg_wr, 1'b0);

    do_op(2'b10, 5'd1, 1'b1, 32'hFFFF_0000, 32'h0000_0104);
    do_op(2'b11, 5'd3, 1'b1, 32'h5555_5555, 32'h0);

    // A stray response in IDLE does nothing.
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_wr", reg_wr, 1'b0);
    chk("idle_rvalid_err", load_err, 1'b0);
    chk("idle_rvalid_ir", instret, ir_exp());
    chk("idle_rvalid_ready", in_ready, 1'b1);

    // Reset while waiting for memory drops the pending load.
    in_sel = 2'b01; in_rd = 5'd4; in_wr_en = 1'b1; in_funct3 = 3'd2; in_addr_lo = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_ret = 0;
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_wa", wa, 5'd0);
    chk("midrst_wda", wda, 32'd0);
    chk("midrst_instret", instret, 64'd0);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    chk("midrst_wr", reg_wr, 1'b0);
    chk("midrst_err", load_err, 1'b0);
    chk("midrst_wa2", wa, 5'd0);
    chk("midrst_wda2", wda, 32'd0);
    chk("midrst_ir2", instret, 64'd0);
    chk("midrst_ready2", in_ready, 1'b1);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'b01) begin
        do_load(3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom), 1'($urandom),
                $urandom, int'($urandom_range(0, 3)), 1'($urandom));
      end else begin
        do_op(sel, 5'($urandom), 1'($urandom), $urandom, $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("rand_gap_wr", reg_wr, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
